// File: rtl/shift_cmp_pipe.sv
// Four-mode ALU (add / arithmetic shift / signed max / xor) behind a DEPTH-cycle pipeline with a hold freeze and a tiny FSM.
// Defining CHECKSUM_EN adds a running XOR of every emitted result; otherwise the checksum field is tied to zero.
module shift_cmp_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    hold,
   input  logic signed [WIDTH-1:0] wire3,
   input  logic signed [WIDTH-1:0] wire2,
   input  logic [4:0]              wire1,
   input  logic [1:0]              wire0,
   output logic                    out_valid,
   output logic [2*WIDTH+9:0]      y
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] stg_dat_q [DEPTH];
   logic [WIDTH-1:0] stg_dat_d [DEPTH];
   logic [DEPTH-1:0] stg_vld_q, stg_vld_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] op_res;
   logic [WIDTH-1:0] checksum;
   logic             accept;
   logic             load_last;

   assign accept = in_valid & ~hold;

   always_comb begin
      op_res = '0;
      case (wire0)
         2'b00: op_res = wire3 + wire2;
         2'b01: if ({1'b0, wire1} < 6'(WIDTH)) op_res = wire3 <<< wire1;
         2'b10: op_res = (wire3 > wire2) ? wire3 : wire2;
         default: op_res = wire3 ^ wire2;
      endcase
   end

   // Data only moves with a valid behind it, so the last stage keeps the last emitted result.
   always_comb begin
      stg_dat_d = stg_dat_q;
      stg_vld_d = stg_vld_q;
      if (!hold) begin
         stg_vld_d[0] = accept;
         if (accept) stg_dat_d[0] = op_res;
         for (int i = 1; i < DEPTH; i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            if (stg_vld_q[i-1]) stg_dat_d[i] = stg_dat_q[i-1];
         end
      end
   end

   assign load_last = ~hold & stg_vld_d[DEPTH-1];

   always_comb begin
      cnt_d = cnt_q;
      if (load_last && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (hold) state_d = HOLD;
            else if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (hold) state_d = HOLD;
            else if (!(|stg_vld_q) && !in_valid) state_d = IDLE;
         end
         HOLD: begin
            if (!hold) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         stg_vld_q <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < DEPTH; i++) stg_dat_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         stg_vld_q <= stg_vld_d;
         cnt_q     <= cnt_d;
         stg_dat_q <= stg_dat_d;
      end
   end

`ifdef CHECKSUM_EN
   logic [WIDTH-1:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (load_last) chk_d = chk_q ^ stg_dat_d[DEPTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chk_q <= '0;
      else     chk_q <= chk_d;
   end

   assign checksum = chk_q;
`else
   assign checksum = '0;
`endif

   // A result frozen in the last stage stays invisible until hold drops.
   assign out_valid = stg_vld_q[DEPTH-1] & ~hold;
   assign y         = {stg_dat_q[DEPTH-1], checksum, cnt_q, state_q};

endmodule

// File: doc/shift_cmp_pipe.md
SHIFT_CMP_PIPE -- requirements
Module: shift_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (legal 4..32).
REQ-002 SHALL have parameter DEPTH, default 3, pipeline latency in cycles (legal 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set valid this cycle.
REQ-006 SHALL have port hold  input  1  freeze pipeline while high.
REQ-007 SHALL have port wire3  input  WIDTH signed  operand A.
REQ-008 SHALL have port wire2  input  WIDTH signed  operand B.
REQ-009 SHALL have port wire1  input  5  shift amount.
REQ-010 SHALL have port wire0  input  2  op mode.
REQ-011 SHALL have port out_valid  output  1  y result field valid.
REQ-012 SHALL have port y  output  2*WIDTH+10  {result[WIDTH], checksum[WIDTH], count[8], state[2]}.

Function
REQ-013 Stage 0 op by wire0: 00 A+B wrapped to WIDTH; 01 A<<<wire1, zero when wire1>=WIDTH; 10 signed max(A,B); 11 A^B.
REQ-014 Result of a set accepted at edge N SHALL appear on y.result with out_valid=1 after edge N+DEPTH-1+k, where k = cycles spent with hold high.
REQ-015 Set accepted only when in_valid=1, hold=0, rst=0; sets presented while hold=1 SHALL be dropped, not queued.
REQ-016 hold=1 SHALL freeze all pipeline stages, valid bits, count and checksum; out_valid SHALL be 0 while hold=1.
REQ-017 y.result SHALL hold last emitted value when out_valid=0.
REQ-018 FSM states IDLE=2'b00, RUN=2'b01, HOLD=2'b10; 2'b11 unreachable, SHALL recover to IDLE next edge.
REQ-019 IDLE->RUN on in_valid&~hold; RUN->HOLD on hold; HOLD->RUN on ~hold; RUN->IDLE when no valid in any stage and in_valid=0; IDLE->HOLD on hold.
REQ-020 HOLD->RUN SHALL occur even if pipeline empty; RUN->IDLE then follows on next qualifying edge.
REQ-021 count SHALL increment by 1 per out_valid cycle, saturating at 8'hFF.
REQ-022 Back-to-back in_valid SHALL sustain one result per cycle; no bubbles inserted.

Reset
REQ-023 rst=1 SHALL immediately clear all stages, valid bits, result, checksum, count to 0, state to IDLE, out_valid to 0.
REQ-024 rst asserted mid-operation SHALL discard all in-flight sets; none emitted after release.
REQ-025 First acceptance possible on first rising edge with rst=0.

Configuration
REQ-026 Macro CHECKSUM_EN defined: checksum SHALL be XOR of every emitted result since reset, updated on out_valid edges.
REQ-027 Macro CHECKSUM_EN undefined: checksum field SHALL be constant 0, no accumulator logic; all other behaviour identical.

Verification (WIDTH=16, DEPTH=3)
REQ-028 rst=1 mid-run with 2 sets in flight -> y=0, out_valid=0 immediately; no results after release.
REQ-029 mode 00, A=16'h7FFF, B=16'h0001, one in_valid -> 3 cycles later out_valid=1, result=16'h8000, count=1, state=01.
REQ-030 mode 01, A=16'h0001, wire1=15 -> 16'h8000; wire1=16 -> 16'h0000.
REQ-031 mode 10, A=16'hFFFB, B=16'h0003 -> 16'h0003; mode 11 same operands -> 16'hFFF8.
REQ-032 two sets, hold high 2 cycles mid-flight with in_valid=1 -> both results delayed 2 cycles, state=10 during hold, held-cycle sets dropped, count=2.
REQ-033 results 16'h00F0 then 16'h0F00 -> checksum=16'h0FF0 with CHECKSUM_EN, 16'h0000 without; 300 results -> count=8'hFF.
